// File: rtl/cam_stream_gen.sv
// Camera-style video stream generator: vsync/href/d byte stream sourced either
// from an external frame buffer (RGB444 read per pixel) or internal colour bars.
module cam_stream_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int HBLANK_CLKS = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        enable_i,
  input  logic        pattern_sel_i,
  output logic        rd_en_o,
  output logic [18:0] rd_addr_o,
  input  logic [11:0] rd_data_i,
  output logic        vsync_o,
  output logic        href_o,
  output logic [7:0]  d_o,
  output logic        frame_done_o,
  output logic        busy_o
);

  localparam int LINE_CLKS = 2 * H_ACTIVE + HBLANK_CLKS;
  localparam int ACT_CLKS  = 2 * H_ACTIVE;
  localparam int VS_CLKS   = VSYNC_LINES * LINE_CLKS;
  localparam int VBP_CLKS  = VBP_LINES * LINE_CLKS;
  localparam int VFP_CLKS  = VFP_LINES * LINE_CLKS;
  localparam int MAX_A     = (VS_CLKS > VBP_CLKS) ? VS_CLKS : VBP_CLKS;
  localparam int MAX_B     = (VFP_CLKS > LINE_CLKS) ? VFP_CLKS : LINE_CLKS;
  localparam int MAX_CLKS  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W     = $clog2(MAX_CLKS + 1);
  localparam int LINE_W    = $clog2(V_ACTIVE + 1);
  localparam int BAR_W     = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, HBLANK, VFP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [18:0]        pixIdx_q, pixIdx_d;
  logic               pat_q, pat_d;
  logic [11:0]        px_q, px_d;
  logic               rdEn_q, rdEn_d;
  logic [18:0]        rdAddr_q, rdAddr_d;
  logic               vsync_q, vsync_d;
  logic               href_q, href_d;
  logic [7:0]         d_q, d_d;
  logic               frameDone_q, frameDone_d;
  logic               busy_q, busy_d;

  logic               startFrame;
  logic [CNT_W-1:0]   colFull;
  logic [2:0]         bar;
  logic [11:0]        barPix, fbPix, pix;

  // Every output is derived from the next state and counters, so the
  // registered outputs line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    line_d     = line_q;
    pixIdx_d   = pixIdx_q;
    pat_d      = pat_q;
    px_d       = px_q;
    rdAddr_d   = rdAddr_q;
    startFrame = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable_i) begin
          startFrame = 1'b1;
        end
      end
      VSYNC: begin
        if (cnt_q == CNT_W'(VS_CLKS - 1)) begin
          state_d = VBP;
          cnt_d   = '0;
        end
      end
      VBP: begin
        if (cnt_q == CNT_W'(VBP_CLKS - 1)) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (cnt_q == CNT_W'(ACT_CLKS - 1)) begin
          state_d = HBLANK;
          cnt_d   = '0;
        end
      end
      HBLANK: begin
        if (cnt_q == CNT_W'(HBLANK_CLKS - 1)) begin
          cnt_d = '0;
          if (line_q == LINE_W'(V_ACTIVE - 1)) begin
            state_d = VFP;
          end else begin
            state_d = ACTIVE;
            line_d  = line_q + LINE_W'(1);
          end
        end
      end
      VFP: begin
        if (cnt_q == CNT_W'(VFP_CLKS - 1)) begin
          cnt_d = '0;
          if (enable_i) begin
            startFrame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Mode and address are latched only here, so mid-frame input changes wait.
    if (startFrame) begin
      state_d  = VSYNC;
      cnt_d    = '0;
      line_d   = '0;
      pixIdx_d = '0;
      rdAddr_d = '0;
      pat_d    = pattern_sel_i;
    end

    // Reads lead each pixel by two cycles, so the first read of a line lands
    // in the tail of VBP or of the HBLANK preceding that line.
    rdEn_d = !pat_d &&
             ((state_d == VBP && cnt_d == CNT_W'(VBP_CLKS - 2)) ||
              (state_d == HBLANK && cnt_d == CNT_W'(HBLANK_CLKS - 2) &&
               line_d != LINE_W'(V_ACTIVE - 1)) ||
              (state_d == ACTIVE && !cnt_d[0] &&
               (cnt_d + CNT_W'(4)) <= CNT_W'(ACT_CLKS)));
    if (rdEn_d) begin
      rdAddr_d = pixIdx_q;
      pixIdx_d = pixIdx_q + 19'd1;
    end

    colFull = cnt_d >> 1;
    bar     = 3'(colFull / CNT_W'(BAR_W));
    barPix  = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
    fbPix   = cnt_d[0] ? px_q : rd_data_i;
    pix     = pat_d ? barPix : fbPix;

    d_d = 8'h00;
    if (state_d == ACTIVE) begin
      if (cnt_d[0]) begin
        d_d = {pix[4], 2'b00, pix[3:0], 1'b0};
      end else begin
        d_d = {pix[11:8], 1'b0, pix[7:5]};
        if (!pat_d) begin
          px_d = rd_data_i;
        end
      end
    end

    vsync_d     = (state_d == VSYNC);
    href_d      = (state_d == ACTIVE);
    busy_d      = (state_d != IDLE);
    frameDone_d = (state_d == VFP) && (cnt_d == CNT_W'(VFP_CLKS - 1));
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      line_q      <= '0;
      pixIdx_q    <= '0;
      pat_q       <= 1'b0;
      px_q        <= '0;
      rdEn_q      <= 1'b0;
      rdAddr_q    <= '0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      d_q         <= '0;
      frameDone_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      pixIdx_q    <= pixIdx_d;
      pat_q       <= pat_d;
      px_q        <= px_d;
      rdEn_q      <= rdEn_d;
      rdAddr_q    <= rdAddr_d;
      vsync_q     <= vsync_d;
      href_q      <= href_d;
      d_q         <= d_d;
      frameDone_q <= frameDone_d;
      busy_q      <= busy_d;
    end
  end

  assign rd_en_o      = rdEn_q;
  assign rd_addr_o    = rdAddr_q;
  assign vsync_o      = vsync_q;
  assign href_o       = href_q;
  assign d_o          = d_q;
  assign frame_done_o = frameDone_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Scoreboard bench for cam_stream_gen: a frame-buffer instance (16x... tiny 4x2
// geometry) and a colour-bar instance (16x2), checked against a pixel-level model.
module tb_cam_stream_gen;

  localparam int HA = 4, VA = 2, HBL = 4, VSL = 1, VBL = 1, VFL = 1;
  localparam int HB = 16;
  localparam int LINE_A  = 2 * HA + HBL;
  localparam int LINE_B  = 2 * HB + HBL;
  localparam int FRAME_A = (VSL + VBL + VFL + VA) * LINE_A;
  localparam int FRAME_B = (VSL + VBL + VFL + VA) * LINE_B;

  logic        pclk = 1'b0;
  logic        reset_n;
  logic        enA, patA, enB, patB;
  logic        rdEnA, rdEnB, vsA, vsB, hrefA, hrefB, fdA, fdB, busyA, busyB;
  logic [18:0] rdAddrA, rdAddrB;
  logic [11:0] rdDataA = '0, rdDataB = '0;
  logic [7:0]  dA, dB;

  logic [11:0] memA [0:HA*VA-1];
  logic [11:0] memB [0:HB*VA-1];

  logic [7:0]  expBytesA[$];
  int          expAddrA[$];
  logic [7:0]  expBytesB[$];

  int  errors = 0, checks = 0;
  bit  expectContA = 1'b0;

  always #5 pclk = ~pclk;

  cam_stream_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .HBLANK_CLKS(HBL),
                   .VSYNC_LINES(VSL), .VBP_LINES(VBL), .VFP_LINES(VFL)) dutA (
    .pclk(pclk), .reset_n(reset_n), .enable_i(enA), .pattern_sel_i(patA),
    .rd_en_o(rdEnA), .rd_addr_o(rdAddrA), .rd_data_i(rdDataA),
    .vsync_o(vsA), .href_o(hrefA), .d_o(dA), .frame_done_o(fdA), .busy_o(busyA));

  cam_stream_gen #(.H_ACTIVE(HB), .V_ACTIVE(VA), .HBLANK_CLKS(HBL),
                   .VSYNC_LINES(VSL), .VBP_LINES(VBL), .VFP_LINES(VFL)) dutB (
    .pclk(pclk), .reset_n(reset_n), .enable_i(enB), .pattern_sel_i(patB),
    .rd_en_o(rdEnB), .rd_addr_o(rdAddrB), .rd_data_i(rdDataB),
    .vsync_o(vsB), .href_o(hrefB), .d_o(dB), .frame_done_o(fdB), .busy_o(busyB));

  // Synchronous-read frame buffers: data appears the cycle after the strobe.
  always @(posedge pclk) begin
    if (rdEnA) rdDataA <= memA[rdAddrA[2:0]];
    if (rdEnB) rdDataB <= memB[rdAddrB[4:0]];
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportExtra(input string name, input int actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got 0x%0h, expected nothing (queue empty)", name, actual);
  endtask

  function automatic logic [7:0] hiByte(input logic [11:0] p);
    return {p[11:8], 1'b0, p[7:5]};
  endfunction

  function automatic logic [7:0] loByte(input logic [11:0] p);
    return {p[4], 2'b00, p[3:0], 1'b0};
  endfunction

  task automatic pushFbFrameA();
    for (int a = 0; a < HA * VA; a++) begin
      expAddrA.push_back(a);
      expBytesA.push_back(hiByte(memA[a]));
      expBytesA.push_back(loByte(memA[a]));
    end
  endtask

  task automatic pushBarFrameB();
    logic [11:0] p;
    int k;
    for (int ln = 0; ln < VA; ln++) begin
      for (int col = 0; col < HB; col++) begin
        k = col / (HB / 8);
        p = {((k & 4) != 0) ? 4'hF : 4'h0, ((k & 2) != 0) ? 4'hF : 4'h0,
             ((k & 1) != 0) ? 4'hF : 4'h0};
        expBytesB.push_back(hiByte(p));
        expBytesB.push_back(loByte(p));
      end
    end
  endtask

  // Level wait with a cycle budget; 0 fdA, 1 hrefA, 2 vsA, 3 fdB, 4 hrefB.
  task automatic waitFor(input int which, input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge pclk);
      case (which)
        0: seen = fdA;
        1: seen = hrefA;
        2: seen = vsA;
        3: seen = fdB;
        default: seen = hrefB;
      endcase
    end
    checkOutput({"wait ", name}, int'(seen), 1);
  endtask

  task automatic applyStimulus(input logic en, input logic pat, input bit toB);
    @(negedge pclk);
    if (toB) begin enB = en; patB = pat; end
    else     begin enA = en; patA = pat; end
  endtask

  // Monitor for the frame-buffer instance: byte/address scoreboard plus timing.
  int cyc = 0, vsRunA = 0, hrefRunA = 0, riseCycA = 0, linesA = 0;
  int fdCountA = 0, zeroViolA = 0, overlapA = 0;
  bit riseValidA = 1'b0, prevVsA = 1'b0, prevHrefA = 1'b0;
  logic [7:0] wantByteA;
  int wantAddrA;

  always @(negedge pclk) begin
    cyc++;
    if (!reset_n) begin
      prevVsA = 1'b0; prevHrefA = 1'b0; vsRunA = 0; hrefRunA = 0;
      riseValidA = 1'b0; linesA = 0;
    end else begin
      if (hrefA) begin
        if (expBytesA.size() == 0) reportExtra("byteA", dA);
        else begin
          wantByteA = expBytesA.pop_front();
          checkOutput("byteA", dA, wantByteA);
        end
      end else if (dA != 8'h00) zeroViolA++;
      if (hrefA && vsA) overlapA++;
      if (rdEnA) begin
        if (expAddrA.size() == 0) reportExtra("rd_addrA", rdAddrA);
        else begin
          wantAddrA = expAddrA.pop_front();
          checkOutput("rd_addrA", rdAddrA, wantAddrA);
        end
      end
      if (vsA) begin
        if (!prevVsA) begin
          if (riseValidA && expectContA) checkOutput("frame periodA", cyc - riseCycA, FRAME_A);
          riseCycA = cyc; riseValidA = 1'b1; linesA = 0; vsRunA = 0;
        end
        vsRunA++;
      end else if (prevVsA) checkOutput("vsync lengthA", vsRunA, VSL * LINE_A);
      if (hrefA) begin
        if (!prevHrefA) begin linesA++; hrefRunA = 0; end
        hrefRunA++;
      end else if (prevHrefA) checkOutput("href lengthA", hrefRunA, 2 * HA);
      if (fdA) begin
        fdCountA++;
        if (riseValidA) checkOutput("frame_done timingA", cyc - riseCycA, FRAME_A - 1);
        checkOutput("lines per frameA", linesA, VA);
      end
      prevVsA = vsA; prevHrefA = hrefA;
    end
  end

  // Monitor for the colour-bar instance.
  int fdCountB = 0, rdEnSeenB = 0, zeroViolB = 0;
  logic [7:0] wantByteB;

  always @(negedge pclk) begin
    if (reset_n) begin
      if (hrefB) begin
        if (expBytesB.size() == 0) reportExtra("byteB", dB);
        else begin
          wantByteB = expBytesB.pop_front();
          checkOutput("byteB", dB, wantByteB);
        end
      end else if (dB != 8'h00) zeroViolB++;
      if (rdEnB) rdEnSeenB++;
      if (fdB) fdCountB++;
    end
  end

  initial begin
    reset_n = 1'b0;
    enA = 1'b0; patA = 1'b0; enB = 1'b0; patB = 1'b1;
    for (int i = 0; i < HA * VA; i++) memA[i] = 12'($urandom);
    memA[0] = 12'hABC;
    for (int i = 0; i < HB * VA; i++) memB[i] = 12'($urandom);

    repeat (3) @(negedge pclk);
    checkOutput("reset vsync", vsA, 0);
    checkOutput("reset href", hrefA, 0);
    checkOutput("reset d", dA, 0);
    checkOutput("reset rd_en", rdEnA, 0);
    checkOutput("reset rd_addr", rdAddrA, 0);
    checkOutput("reset frame_done", fdA, 0);
    checkOutput("reset busy", busyA, 0);
    @(negedge pclk);
    reset_n = 1'b1;
    repeat (2) @(negedge pclk);
    checkOutput("idle busy", busyA, 0);

    // Three back-to-back frames; pattern toggle mid-frame must be ignored.
    pushFbFrameA(); pushFbFrameA(); pushFbFrameA();
    expectContA = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFor(0, "frame1 doneA", 3 * FRAME_A);
    waitFor(1, "frame2 hrefA", 2 * FRAME_A);
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge pclk);
    patA = 1'b0;
    waitFor(0, "frame2 doneA", 2 * FRAME_A);
    waitFor(1, "frame3 hrefA", 2 * FRAME_A);
    repeat ($urandom_range(0, 5)) @(negedge pclk);
    enA = 1'b0;
    waitFor(0, "frame3 doneA", 2 * FRAME_A);
    expectContA = 1'b0;
    repeat (2) @(negedge pclk);
    checkOutput("busy after stopA", busyA, 0);
    checkOutput("vsync after stopA", vsA, 0);
    checkOutput("frames doneA", fdCountA, 3);
    checkOutput("bytes leftA", expBytesA.size(), 0);

    // Re-enable with fresh frame-buffer contents.
    for (int i = 0; i < HA * VA; i++) memA[i] = 12'($urandom);
    pushFbFrameA();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFor(2, "reenable vsyncA", 10);
    enA = 1'b0;
    waitFor(0, "reenable doneA", 2 * FRAME_A);
    repeat (2) @(negedge pclk);
    checkOutput("addrs leftA", expAddrA.size(), 0);

    // Asynchronous reset mid-line abandons the frame.
    pushFbFrameA();
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitFor(1, "pre-reset hrefA", 2 * FRAME_A);
    repeat ($urandom_range(1, 4)) @(negedge pclk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async reset href", hrefA, 0);
    checkOutput("async reset d", dA, 0);
    checkOutput("async reset busy", busyA, 0);
    checkOutput("async reset rd_addr", rdAddrA, 0);
    expBytesA.delete();
    expAddrA.delete();
    repeat (2) @(negedge pclk);
    pushFbFrameA();
    reset_n = 1'b1;
    waitFor(2, "post-reset vsyncA", 10);
    enA = 1'b0;
    waitFor(0, "post-reset doneA", 2 * FRAME_A);
    repeat (2) @(negedge pclk);
    checkOutput("post-reset bytes leftA", expBytesA.size(), 0);
    checkOutput("post-reset busyA", busyA, 0);

    // Colour bars on the wide instance.
    pushBarFrameB(); pushBarFrameB();
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitFor(4, "frame1 hrefB", 2 * FRAME_B);
    patB = 1'b0;
    repeat (4) @(negedge pclk);
    patB = 1'b1;
    waitFor(3, "frame1 doneB", 2 * FRAME_B);
    waitFor(4, "frame2 hrefB", 2 * FRAME_B);
    enB = 1'b0;
    waitFor(3, "frame2 doneB", 2 * FRAME_B);
    repeat (2) @(negedge pclk);
    checkOutput("busy after stopB", busyB, 0);
    checkOutput("frames doneB", fdCountB, 2);
    checkOutput("bytes leftB", expBytesB.size(), 0);
    checkOutput("rd_en in pattern modeB", rdEnSeenB, 0);
    checkOutput("d nonzero outside hrefA", zeroViolA, 0);
    checkOutput("d nonzero outside hrefB", zeroViolB, 0);
    checkOutput("vsync/href overlapA", overlapA, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
